// File: rtl/clock_pkg.sv
// Shared display constants: seven-segment glyphs,
// the logical "all off" pattern and seg bit positions.
package clock_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high g..a glyph.
// Purely combinational.
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_8;
    unique case (nib_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      4'hF: glyph_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with guard
// slot, frame-latched shadows, blink and LZB.
module seg_scan_mux
  import clock_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 250,
  parameter int ACTIVE_LOW   = 1,
  parameter int LZB          = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   show
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ?
                      $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  localparam logic [7:0] SEG_INV =
    (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SHOW_INV =
    (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frm_q, frm_d;
  logic                    blink_q, blink_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blk_q, blk_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   show_q, show_d;

  logic [3:0]              nib;
  logic [6:0]              glyph;
  logic [NUM_DIGITS:0]     lz;
  logic                    slot_end;
  logic                    frame_end;
  logic                    blank;
  logic                    dark;

  assign nib = dig_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_dec (
    .nib_i   (nib),
    .glyph_o (glyph)
  );

  // lz[i]: digit i and every digit above it are zero
  always_comb begin
    lz = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz[i] = lz[i+1] && (dig_q[4*i +: 4] == 4'h0);
    end
  end

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == IDX_MAX);
  assign blank     = (LZB != 0) && (idx_q != '0) &&
                     lz[idx_q];
  assign dark      = !blink_q && blk_q[idx_q];

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    dig_d   = dig_q;
    dp_d    = dp_q;
    blk_d   = blk_q;
    seg_d   = SEG_OFF;
    show_d  = '0;
    if (enable) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) begin
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      if (frame_end) begin
        if (frm_q == FRM_MAX) begin
          frm_d   = '0;
          blink_d = ~blink_q;
        end else begin
          frm_d = frm_q + 1'b1;
        end
      end
      if (cnt_q == '0 && idx_q == '0) begin
        dig_d = digits_in;
        dp_d  = dp_in;
        blk_d = blink_mask;
      end
      // cnt==0 is the guard slot: everything stays off
      if (cnt_q != '0) begin
        show_d[idx_q] = 1'b1;
        if (!dark) begin
          seg_d[SEG_DP]      = dp_q[idx_q];
          seg_d[SEG_G:SEG_A] = blank ? 7'h00 : glyph;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      blink_q <= 1'b1;
      dig_q   <= '0;
      dp_q    <= '0;
      blk_q   <= '0;
      seg_q   <= SEG_OFF ^ SEG_INV;
      show_q  <= SHOW_INV;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      blk_q   <= blk_d;
      seg_q   <= seg_d ^ SEG_INV;
      show_q  <= show_d ^ SHOW_INV;
    end
  end

  assign seg  = seg_q;
  assign show = show_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: 4 digits, 4-cycle slots,
// 2-frame blink, active-low; LZB off and on.
module tb_seg_scan_mux;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blink = '0;
  logic [7:0]  seg0, seg1;
  logic [3:0]  show0, show1;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
    .ACTIVE_LOW(1), .LZB(0)
  ) u0 (
    .clk(clk), .rst(rst), .enable(enable),
    .digits_in(digits), .dp_in(dp),
    .blink_mask(blink), .seg(seg0), .show(show0)
  );

  seg_scan_mux #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
    .ACTIVE_LOW(1), .LZB(1)
  ) u1 (
    .clk(clk), .rst(rst), .enable(enable),
    .digits_in(digits), .dp_in(dp),
    .blink_mask(blink), .seg(seg1), .show(show1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [11:0] got,
                     logic [11:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, got, want, $time);
    end
  endtask

  // Reference glyphs, a..g in bits 0..6
  logic [6:0] gt [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: everything derives from t, the number of
  // enabled cycles since reset.
  int unsigned t;
  int          mc, md, mf;
  logic        mvis;
  logic        mv = 1'b0;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_blk;
  logic [7:0]  p0, p1;
  logic [11:0] e0, e1;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_dig = '0; m_dp = '0; m_blk = '0;
      e0 = 12'hFFF; e1 = 12'hFFF; mv = 1'b1;
    end else if (!enable) begin
      e0 = 12'hFFF; e1 = 12'hFFF;
    end else begin
      mc = int'(t % SD);
      md = int'((t / SD) % N);
      mf = int'(t / (SD * N));
      mvis = ((mf / BF) % 2) == 0;
      if (mc == 0) begin
        e0 = 12'hFFF; e1 = 12'hFFF;
      end else begin
        p0 = {m_dp[md], gt[m_dig[4*md +: 4]]};
        p1 = p0;
        if (md >= 1 && (m_dig >> (4 * md)) == 16'h0)
          p1[6:0] = 7'h00;
        if (!mvis && m_blk[md]) begin
          p0 = 8'h00; p1 = 8'h00;
        end
        e0 = {~(4'b0001 << md), ~p0};
        e1 = {~(4'b0001 << md), ~p1};
      end
      if (mc == 0 && md == 0) begin
        m_dig = digits; m_dp = dp; m_blk = blink;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("model.lzb0", {show0, seg0}, e0);
      chk("model.lzb1", {show1, seg1}, e1);
    end
  end

  typedef struct {
    logic        r;
    logic [15:0] dg;
    logic [3:0]  xs;
    logic [7:0]  xg;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic r, logic [15:0] dg,
                              logic [3:0] xs, logic [7:0] xg);
    vec_t v;
    v.r = r; v.dg = dg; v.xs = xs; v.xg = xg;
    return v;
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(logic [15:0] dg, logic [3:0] bl);
    rst = 1'b1; enable = 1'b1;
    digits = dg; blink = bl; dp = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 16'h1234, 4'hF, 8'hFF);
    tbl[1]  = mk(0, 16'h1234, 4'hF, 8'hFF);
    tbl[2]  = mk(0, 16'h1234, 4'hE, 8'h99);
    tbl[3]  = mk(0, 16'h1234, 4'hE, 8'h99);
    tbl[4]  = mk(0, 16'h1234, 4'hE, 8'h99);
    tbl[5]  = mk(0, 16'h1234, 4'hF, 8'hFF);
    tbl[6]  = mk(0, 16'h1234, 4'hD, 8'hB0);
    tbl[7]  = mk(0, 16'h1234, 4'hD, 8'hB0);
    tbl[8]  = mk(0, 16'h1234, 4'hD, 8'hB0);
    tbl[9]  = mk(0, 16'h1234, 4'hF, 8'hFF);
    tbl[10] = mk(0, 16'h1234, 4'hB, 8'hA4);
    tbl[11] = mk(0, 16'h1234, 4'hB, 8'hA4);
    tbl[12] = mk(0, 16'h1234, 4'hB, 8'hA4);
    tbl[13] = mk(0, 16'h1234, 4'hF, 8'hFF);
    tbl[14] = mk(0, 16'h1234, 4'h7, 8'hF9);
    tbl[15] = mk(0, 16'h1234, 4'h7, 8'hF9);
    tbl[16] = mk(0, 16'h1234, 4'h7, 8'hF9);
    tbl[17] = mk(0, 16'h1234, 4'hF, 8'hFF);

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].r;
      digits = tbl[i].dg;
      @(negedge clk);
      chk($sformatf("scan[%0d]", i), {show0, seg0},
          {tbl[i].xs, tbl[i].xg});
    end

    // Shadow update mid-frame must not tear
    do_reset(16'h1234, 4'h0);
    step(9);
    digits = 16'h5678;
    step(1);
    chk("tear.d2", {show0, seg0}, {4'hB, 8'hA4});
    step(4);
    chk("tear.d3", {show0, seg0}, {4'h7, 8'hF9});
    step(4);
    chk("tear.new_d0", {show0, seg0}, {4'hE, 8'h80});
    step(4);
    chk("tear.new_d1", {show0, seg0}, {4'hD, 8'hF8});

    do_reset(16'h1234, 4'b0001);
    step(34);
    chk("blink.f2_d0", {show0, seg0}, {4'hE, 8'hFF});
    step(4);
    chk("blink.f2_d1", {show0, seg0}, {4'hD, 8'hB0});
    step(28);
    chk("blink.f4_d0", {show0, seg0}, {4'hE, 8'h99});

    do_reset(16'h0040, 4'h0);
    step(2);
    chk("lzb.d0", {show1, seg1}, {4'hE, 8'hC0});
    step(4);
    chk("lzb.d1", {show1, seg1}, {4'hD, 8'h99});
    step(4);
    chk("lzb.d2", {show1, seg1}, {4'hB, 8'hFF});
    step(4);
    chk("lzb.d3", {show1, seg1}, {4'h7, 8'hFF});
    chk("nolzb.d3", {show0, seg0}, {4'h7, 8'hC0});
    do_reset(16'h0000, 4'h0);
    step(2);
    chk("lzb0.d0", {show1, seg1}, {4'hE, 8'hC0});
    step(4);
    chk("lzb0.d1", {show1, seg1}, {4'hD, 8'hFF});

    do_reset(16'h1234, 4'h0);
    step(6);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("en_low", {show0, seg0}, 12'hFFF);
    end
    enable = 1'b1;
    step(1);
    chk("en_resume", {show0, seg0}, {4'hD, 8'hB0});
    step(2);
    chk("en_guard", {show0, seg0}, 12'hFFF);

    // Reset while blinked dark in frame 2, idx 3
    do_reset(16'h1234, 4'b0001);
    step(46);
    rst = 1'b1;
    step(1);
    chk("rst.off", {show0, seg0}, 12'hFFF);
    rst = 1'b0;
    step(1);
    chk("rst.guard", {show0, seg0}, 12'hFFF);
    step(1);
    chk("rst.d0_lit", {show0, seg0}, {4'hE, 8'h99});

    do_reset(16'($urandom), 4'($urandom));
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0)
        digits = ($urandom_range(0, 1) != 0) ?
                 16'($urandom) : 16'($urandom_range(0, 255));
      if ($urandom_range(0, 29) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 29) == 0) blink = 4'($urandom);
      enable = $urandom_range(0, 9) != 0;
      rst = $urandom_range(0, 299) == 0;
    end
    rst = 1'b0;
    enable = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits (range 2..16).
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per digit slot (range 4..2^20).
REQ-003 Parameter BLINK_FRAMES, default 250, full scan frames per blink half-period (range 1..1023).
REQ-004 Parameter ACTIVE_LOW, default 1; 1 means seg and show are driven low-active, 0 means high-active.
REQ-005 Parameter LZB, default 0; 1 enables leading-zero blanking.
REQ-006 clk  in  1  single system clock; all logic is in this clock domain.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 enable  in  1  scan enable; 0 forces the display dark.
REQ-009 digits_in  in  4*NUM_DIGITS  hex nibble per digit; nibble i is digit i, and digit 0 is least significant.
REQ-010 dp_in  in  NUM_DIGITS  decimal point per digit.
REQ-011 blink_mask  in  NUM_DIGITS  bit i set makes digit i blink.
REQ-012 seg  out  8  seg[7] is dp and seg[6:0] is g..a; the field is registered.
REQ-013 show  out  NUM_DIGITS  one-hot digit select; the field is registered.

Function
REQ-014 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap; idx SHALL advance (NUM_DIGITS-1 wraps to 0) in the cycle where cnt==SCAN_DIV-1.
REQ-015 Outputs SHALL be registered: seg/show in cycle t+1 reflect cnt/idx/shadow state in cycle t.
REQ-016 Guard slot: when cnt==0, show SHALL be all inactive and seg all inactive (anti-ghosting).
REQ-017 Display slot: when cnt is 1..SCAN_DIV-1, show SHALL activate only bit idx and seg SHALL carry the pattern for shadow digit idx.
REQ-018 Shadow registers (digits, dp, blink_mask) SHALL capture the inputs only when idx==0 and cnt==0, so there is no tearing mid-frame.
REQ-019 Decode: 0-9 and A-F use standard seven-segment glyphs; dp comes from shadow dp bit idx.
REQ-020 blink_phase resets to 1 (visible); the frame counter increments at each frame end (idx==NUM_DIGITS-1, cnt==SCAN_DIV-1).
REQ-021 On reaching BLINK_FRAMES-1 at a frame end, the frame counter SHALL clear and blink_phase SHALL toggle.
REQ-022 When blink_phase==0 and the shadow blink bit is set, the digit's seg SHALL be all inactive (dp included) while show still scans.
REQ-023 With LZB=1, digit i (i>=1) SHALL have g..a blanked when it and all higher digits are zero; digit 0 is never blanked; dp is unaffected.
REQ-024 When enable==0, cnt, idx, the frame counter and blink_phase SHALL hold, and seg/show SHALL be inactive from the next cycle.
REQ-025 When enable rises, scanning SHALL resume from the held state without a skip.
REQ-026 Polarity: every inactive/active level SHALL follow ACTIVE_LOW (inactive is all 1s when ACTIVE_LOW=1).
REQ-027 Counter widths SHALL be clog2-sized from the parameters, with no truncation at maximum parameter values.

Reset
REQ-028 When rst==1 at a clk edge, cnt, idx and the frame counter SHALL clear to 0, blink_phase SHALL be set to 1, and the shadows SHALL clear to 0.
REQ-029 Reset SHALL drive seg and show inactive from the following cycle.
REQ-030 rst asserted mid-slot or mid-frame SHALL take priority over enable and over the counters.
REQ-031 The first display slot after rst deassert SHALL be digit 0, preceded by one guard cycle.

Structure
REQ-032 Shared package clock_pkg SHALL hold the 16 glyph constants, SEG_OFF, and the seg bit-index constants.
REQ-033 One sub-module, seg7_decode (nibble to 7-bit glyph, combinational), SHALL be instantiated once and fed by the idx-selected shadow nibble.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1)
REQ-034 Scan: rst then digits_in=16'h1234.
  - show SHALL be 1111,1110,1110,1110,1111,1101,... in order.
  - seg for digit 0 SHALL be the glyph "4".
REQ-035 Tearing: change digits_in to 16'h5678 while idx==2.
  - digits 2 and 3 SHALL still show 2 and 1.
  - 8,7,6,5 SHALL appear from the next frame.
REQ-036 Blink: blink_mask=4'b0001.
  - digit 0 seg SHALL be dark during frames 2-3 and lit during frames 0-1 and 4-5 (frame counting starts at 0 at rst).
  - the other digits SHALL always be lit.
REQ-037 LZB=1 with digits_in=16'h0040.
  - digits 3 and 2 SHALL be dark, and digits 1 and 0 SHALL show 4 and 0.
  - with 16'h0000, only digit 0 SHALL show 0.
REQ-038 enable low for 10 cycles mid-slot: all outputs SHALL be 1 throughout, and scanning SHALL resume at the same idx/cnt.
REQ-039 rst pulsed at idx==3: the next cycle SHALL be all inactive, followed by guard then digit 0, with blink_phase==1.
